cmd_packet_encoder: RTL and testbench

- Host-side producer of the command packet stream consumed by the dataflow decoder. It is the writer end of the command FIFO that feeds the decoder.
- Takes one job configuration plus a stream of task descriptors from the host/loader and emits correctly typed packets in the required order: stream header, weights boundary, tasks, replay markers.
- Sits between the host loader and the command FIFO input. It never writes when the FIFO is full.

---
 rtl/cmd_packet_encoder_pkg.sv | 26 ++
 rtl/cmd_packet_encoder_if.sv | 44 ++++
 rtl/cmd_packet_encoder.sv | 130 +++++++++++++
 tb/tb_cmd_packet_encoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cmd_packet_encoder_pkg.sv
// Shared command-packet definitions used by the encoder and the dataflow decoder.
package cmd_packet_encoder_pkg;

    // Packet type field, top two bits of every packet.
    localparam logic [1:0] PKT_TASK   = 2'b00;
    localparam logic [1:0] PKT_REPLAY = 2'b01;
    localparam logic [1:0] PKT_NUMFV  = 2'b10;
    localparam logic [1:0] PKT_WB     = 2'b11;

    // Iteration mask location inside a task payload.
    localparam int MASK_LSB = 10;
    localparam int MASK_MSB = 13;

    // Header value widths.
    localparam int NUMFV_W = 5;
    localparam int WB_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_FV,
        ST_HDR_WB,
        ST_TASKS,
        ST_REPLAY
    } enc_state_e;

endpackage

// File: rtl/cmd_packet_encoder_if.sv
// Host-loader / command-FIFO side signals of the packet encoder.
interface cmd_packet_encoder_if #(
    parameter int PKT_W    = 16,
    parameter int MAX_ITER = 4,
    parameter int CNT_W    = 16
);
    import cmd_packet_encoder_pkg::*;

    localparam int ITER_W = $clog2(MAX_ITER) + 1;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [NUMFV_W-1:0] cfg_num_fv;
    logic [WB_W-1:0]    cfg_wb;
    logic [ITER_W-1:0]  cfg_iters;
    logic               task_valid;
    logic               task_ready;
    logic [PKT_W-3:0]   task_payload;
    logic               task_last;
    logic               fifo_full;
    logic               fifo_wr_en;
    logic [PKT_W-1:0]   fifo_wr_data;
    logic               busy;
    logic               job_done;
    logic               cfg_err;
    logic [CNT_W-1:0]   pkt_count;

    // Environment view: drives config, tasks and FIFO status.
    modport master (
        output cfg_valid, cfg_num_fv, cfg_wb, cfg_iters,
        output task_valid, task_payload, task_last, fifo_full,
        input  cfg_ready, task_ready, fifo_wr_en, fifo_wr_data,
        input  busy, job_done, cfg_err, pkt_count
    );

    // Encoder view.
    modport slave (
        input  cfg_valid, cfg_num_fv, cfg_wb, cfg_iters,
        input  task_valid, task_payload, task_last, fifo_full,
        output cfg_ready, task_ready, fifo_wr_en, fifo_wr_data,
        output busy, job_done, cfg_err, pkt_count
    );

endinterface

// File: rtl/cmd_packet_encoder.sv
// Writer end of the command FIFO: emits header, weights boundary, tasks and
// replay markers for one job, never writing while the FIFO is full.
module cmd_packet_encoder
    import cmd_packet_encoder_pkg::*;
#(
    parameter int PKT_W    = 16,
    parameter int MAX_ITER = 4,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    cmd_packet_encoder_if.slave  bus_if
);

    localparam int ITER_W = $clog2(MAX_ITER) + 1;
    localparam int PW     = PKT_W - 2;

    enc_state_e         state_q, state_d;
    logic [NUMFV_W-1:0] num_fv_q, num_fv_d;
    logic [WB_W-1:0]    wb_q, wb_d;
    logic [ITER_W-1:0]  iters_q, iters_d;
    logic [ITER_W-1:0]  iter_cnt_q, iter_cnt_d;
    logic               cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;

    logic               wr_en;
    logic [PKT_W-1:0]   wr_data;
    logic               cfg_ready, task_ready, job_done;
    logic               iters_legal;

    function automatic logic [PKT_W-1:0] mk_pkt(input logic [1:0] ptype,
                                                 input logic [PW-1:0] body);
        return {ptype, body};
    endfunction

    assign iters_legal = (bus_if.cfg_iters != '0) &&
                         (bus_if.cfg_iters <= ITER_W'(MAX_ITER));

    // Next-state, FIFO write and handshake decode.
    always_comb begin
        state_d     = state_q;
        num_fv_d    = num_fv_q;
        wb_d        = wb_q;
        iters_d     = iters_q;
        iter_cnt_d  = iter_cnt_q;
        cfg_err_d   = cfg_err_q;
        cfg_ready   = 1'b0;
        task_ready  = 1'b0;
        job_done    = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (bus_if.cfg_valid) begin
                    if (iters_legal) begin
                        num_fv_d   = bus_if.cfg_num_fv;
                        wb_d       = bus_if.cfg_wb;
                        iters_d    = bus_if.cfg_iters;
                        iter_cnt_d = '0;
                        state_d    = ST_HDR_FV;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_HDR_FV: if (!bus_if.fifo_full) begin
                wr_en   = 1'b1;
                wr_data = mk_pkt(PKT_NUMFV, PW'(num_fv_q));
                state_d = ST_HDR_WB;
            end
            ST_HDR_WB: if (!bus_if.fifo_full) begin
                wr_en   = 1'b1;
                wr_data = mk_pkt(PKT_WB, PW'(wb_q));
                state_d = ST_TASKS;
            end
            ST_TASKS: begin
                // Pass-through: the mask field travels untouched in the payload.
                task_ready = !bus_if.fifo_full;
                if (bus_if.task_valid && !bus_if.fifo_full) begin
                    wr_en   = 1'b1;
                    wr_data = mk_pkt(PKT_TASK, bus_if.task_payload);
                    if (bus_if.task_last) state_d = ST_REPLAY;
                end
            end
            ST_REPLAY: if (!bus_if.fifo_full) begin
                wr_en      = 1'b1;
                wr_data    = mk_pkt(PKT_REPLAY, PW'(iter_cnt_q));
                iter_cnt_d = iter_cnt_q + 1'b1;
                if (iter_cnt_q == iters_q - 1'b1) begin
                    job_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pkt_count_d = wr_en ? pkt_count_q + CNT_W'(1) : pkt_count_q;
    end

    // State, latched job configuration and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            num_fv_q    <= '0;
            wb_q        <= '0;
            iters_q     <= '0;
            iter_cnt_q  <= '0;
            cfg_err_q   <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            num_fv_q    <= num_fv_d;
            wb_q        <= wb_d;
            iters_q     <= iters_d;
            iter_cnt_q  <= iter_cnt_d;
            cfg_err_q   <= cfg_err_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign bus_if.cfg_ready    = cfg_ready;
    assign bus_if.task_ready   = task_ready;
    assign bus_if.fifo_wr_en   = wr_en;
    assign bus_if.fifo_wr_data = wr_data;
    assign bus_if.busy         = (state_q != ST_IDLE);
    assign bus_if.job_done     = job_done;
    assign bus_if.cfg_err      = cfg_err_q;
    assign bus_if.pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_cmd_packet_encoder.sv
// Directed-vector bench for cmd_packet_encoder; a second CNT_W=4 instance
// shares the stimulus to observe counter wrap.
module tb_cmd_packet_encoder;

    logic clk;
    logic reset;

    cmd_packet_encoder_if #(.PKT_W(16), .MAX_ITER(4), .CNT_W(16)) bus16 ();
    cmd_packet_encoder_if #(.PKT_W(16), .MAX_ITER(4), .CNT_W(4))  bus4 ();

    cmd_packet_encoder #(.PKT_W(16), .MAX_ITER(4), .CNT_W(16)) dut16 (
        .clk(clk), .reset(reset), .bus_if(bus16));
    cmd_packet_encoder #(.PKT_W(16), .MAX_ITER(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .bus_if(bus4));

    assign bus4.cfg_valid    = bus16.cfg_valid;
    assign bus4.cfg_num_fv   = bus16.cfg_num_fv;
    assign bus4.cfg_wb       = bus16.cfg_wb;
    assign bus4.cfg_iters    = bus16.cfg_iters;
    assign bus4.task_valid   = bus16.task_valid;
    assign bus4.task_payload = bus16.task_payload;
    assign bus4.task_last    = bus16.task_last;
    assign bus4.fifo_full    = bus16.fifo_full;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic [4:0]  nfv;
        logic [3:0]  wb;
        logic [2:0]  it;
        logic        tv;
        logic [13:0] pl;
        logic        tl;
        logic        ff;
        logic        ewr;
        logic [15:0] edat;
        logic        etr;
        logic        ecr;
        logic        ejd;
        logic        eby;
        logic        eerr;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;

    function automatic vec_t mk(logic cv, logic [4:0] nfv, logic [3:0] wb, logic [2:0] it,
                                logic tv, logic [13:0] pl, logic tl, logic ff,
                                logic ewr, logic [15:0] edat, logic etr, logic ecr,
                                logic ejd, logic eby, logic eerr);
        vec_t v;
        v.cv = cv; v.nfv = nfv; v.wb = wb; v.it = it;
        v.tv = tv; v.pl = pl; v.tl = tl; v.ff = ff;
        v.ewr = ewr; v.edat = edat; v.etr = etr; v.ecr = ecr;
        v.ejd = ejd; v.eby = eby; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one row after a rising edge, check at the falling edge.
    task automatic apply(input vec_t v, input string tag);
        bus16.cfg_valid    = v.cv;
        bus16.cfg_num_fv   = v.nfv;
        bus16.cfg_wb       = v.wb;
        bus16.cfg_iters    = v.it;
        bus16.task_valid   = v.tv;
        bus16.task_payload = v.pl;
        bus16.task_last    = v.tl;
        bus16.fifo_full    = v.ff;
        @(negedge clk);
        chk({tag, " wr_en"},      bus16.fifo_wr_en,   v.ewr);
        chk({tag, " wr_data"},    bus16.fifo_wr_data, v.edat);
        chk({tag, " task_ready"}, bus16.task_ready,   v.etr);
        chk({tag, " cfg_ready"},  bus16.cfg_ready,    v.ecr);
        chk({tag, " job_done"},   bus16.job_done,     v.ejd);
        chk({tag, " busy"},       bus16.busy,         v.eby);
        chk({tag, " cfg_err"},    bus16.cfg_err,      v.eerr);
        chk({tag, " pkt_count"},  bus16.pkt_count,    exp_cnt & 'hFFFF);
        chk({tag, " pkt_count4"}, bus4.pkt_count,     exp_cnt & 'hF);
        @(posedge clk);
        #1;
        if (v.ewr) exp_cnt++;
    endtask

    // Write-rule invariants on every cycle out of reset.
    always @(negedge clk) begin
        if (!reset) begin
            chk("no_write_when_full", bus16.fifo_wr_en & bus16.fifo_full, 0);
            if (!bus16.fifo_wr_en) chk("data_zero_when_idle", bus16.fifo_wr_data, 0);
        end
    end

    initial begin
        reset = 1'b1;
        bus16.cfg_valid = 0; bus16.cfg_num_fv = 0; bus16.cfg_wb = 0; bus16.cfg_iters = 0;
        bus16.task_valid = 0; bus16.task_payload = 0; bus16.task_last = 0; bus16.fifo_full = 0;

        // Basic job: 9 / 5 / 4 iterations, three tasks.
        tbl.push_back(mk(1,9,5,4, 0,0,0,0,        0,16'h0000,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        1,16'h8009,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        1,16'hC005,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 1,14'h0423,0,0, 1,16'h0423,1,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 1,14'h0845,0,0, 1,16'h0845,1,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 1,14'h3C67,1,0, 1,16'h3C67,1,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        1,16'h4000,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        1,16'h4001,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        1,16'h4002,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        1,16'h4003,0,0,1,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        0,16'h0000,0,1,0,0,0));
        // Backpressure job: 3 / 10 / 2 iterations, stalls in HDR_WB, TASKS, REPLAY.
        tbl.push_back(mk(1,3,10,2, 0,0,0,0,       0,16'h0000,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,14'h3333,0,0, 1,16'h8003,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1,        0,16'h0000,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1,        0,16'h0000,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1,        0,16'h0000,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        1,16'hC00A,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 1,14'h1111,0,0, 1,16'h1111,1,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        0,16'h0000,1,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 1,14'h2222,1,1, 0,16'h0000,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 1,14'h2222,1,1, 0,16'h0000,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 1,14'h2222,1,1, 0,16'h0000,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 1,14'h2222,1,0, 1,16'h2222,1,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        1,16'h4000,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1,        0,16'h0000,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        1,16'h4001,0,0,1,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        0,16'h0000,0,1,0,0,0));
        // Illegal iteration counts 0 and 5.
        tbl.push_back(mk(1,7,7,0, 0,0,0,0,        0,16'h0000,0,1,0,0,0));
        tbl.push_back(mk(1,7,7,5, 0,0,0,0,        0,16'h0000,0,1,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        0,16'h0000,0,1,0,0,1));
        // Single task, one iteration, zero mask; cfg while busy is ignored.
        tbl.push_back(mk(1,16,15,1, 0,0,0,0,      0,16'h0000,0,1,0,0,1));
        tbl.push_back(mk(1,2,2,2, 0,0,0,0,        1,16'h8010,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        1,16'hC00F,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0, 1,14'h0055,1,0, 1,16'h0055,1,0,0,1,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        1,16'h4000,0,0,1,1,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,        0,16'h0000,0,1,0,0,1));

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset busy",      bus16.busy,       0);
        chk("reset cfg_ready", bus16.cfg_ready,  1);
        chk("reset wr_en",     bus16.fifo_wr_en, 0);
        chk("reset pkt_count", bus16.pkt_count,  0);
        chk("reset cfg_err",   bus16.cfg_err,    0);
        @(posedge clk);
        #1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // Reset in the middle of a five-task job, right after task 2.
        apply(mk(1,4,4,3, 0,0,0,0,        0,16'h0000,0,1,0,0,1), "mid cfg");
        apply(mk(0,0,0,0, 0,0,0,0,        1,16'h8004,0,0,0,1,1), "mid hdr_fv");
        apply(mk(0,0,0,0, 0,0,0,0,        1,16'hC004,0,0,0,1,1), "mid hdr_wb");
        apply(mk(0,0,0,0, 1,14'h0101,0,0, 1,16'h0101,1,0,0,1,1), "mid task1");
        apply(mk(0,0,0,0, 1,14'h0202,0,0, 1,16'h0202,1,0,0,1,1), "mid task2");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        chk("midrst busy",      bus16.busy,       0);
        chk("midrst cfg_ready", bus16.cfg_ready,  1);
        chk("midrst wr_en",     bus16.fifo_wr_en, 0);
        chk("midrst pkt_count", bus16.pkt_count,  0);
        chk("midrst cfg_err",   bus16.cfg_err,    0);
        @(posedge clk);
        #1;

        // 17-packet job: 2 headers, 11 tasks, 4 replays.
        apply(mk(1,1,1,4, 0,0,0,0, 0,16'h0000,0,1,0,0,0), "wrap cfg");
        apply(mk(0,0,0,0, 0,0,0,0, 1,16'h8001,0,0,0,1,0), "wrap hdr_fv");
        apply(mk(0,0,0,0, 0,0,0,0, 1,16'hC001,0,0,0,1,0), "wrap hdr_wb");
        for (int t = 0; t < 11; t++) begin
            logic [13:0] p;
            p = 14'(t * 14'h0111);
            apply(mk(0,0,0,0, 1,p,(t == 10),0, 1,{2'b00,p},1,0,0,1,0), $sformatf("wrap task%0d", t));
        end
        for (int r = 0; r < 4; r++)
            apply(mk(0,0,0,0, 0,0,0,0, 1,16'h4000 | 16'(r),0,0,(r == 3),1,0), $sformatf("wrap rep%0d", r));
        @(negedge clk);
        chk("wrap pkt_count4", bus4.pkt_count,  1);
        chk("wrap pkt_count",  bus16.pkt_count, 17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
